// File: rtl/intra_pred_pkg.sv
// Shared types and helpers for the NxN intra predictor.
// Mode/state encodings, DC fallback value and block-size legality.
package intra_pred_pkg;

  typedef enum logic [1:0] {
    PRED_V    = 2'd0,
    PRED_H    = 2'd1,
    PRED_DC   = 2'd2,
    PRED_RSVD = 2'd3
  } pred_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  function automatic int dc_default(int pixw);
    return 1 << (pixw - 1);
  endfunction

  function automatic bit legal_n(int n);
    return (n == 4) || (n == 8) || (n == 16);
  endfunction

endpackage

// File: rtl/intra_dc_accum.sv
// Sequential DC accumulator: one top/left pair per step, N steps,
// rounding shift applied on the final step.
module intra_dc_accum
  import intra_pred_pkg::*;
#(
  parameter int N    = 8,
  parameter int PIXW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic            top_avail,
  input  logic            left_avail,
  input  logic [N*PIXW-1:0] top_pixels,
  input  logic [N*PIXW-1:0] left_pixels,
  output logic            dc_valid,
  output logic [PIXW-1:0] dc
);

  localparam int LOG2N = $clog2(N);
  localparam int ACCW  = PIXW + LOG2N + 1;
  localparam logic [PIXW-1:0] DC_DEF = PIXW'(dc_default(PIXW));

  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  sum_nx;
  logic [ACCW-1:0]  rnd2;
  logic [ACCW-1:0]  rnd1;
  logic [LOG2N-1:0] step;
  logic [PIXW-1:0]  t_px;
  logic [PIXW-1:0]  l_px;
  logic             unused_bits;

  always_comb begin
    t_px   = top_avail  ? top_pixels[step*PIXW +: PIXW]  : '0;
    l_px   = left_avail ? left_pixels[step*PIXW +: PIXW] : '0;
    sum_nx = acc + ACCW'(t_px) + ACCW'(l_px);
    rnd2   = sum_nx + ACCW'(N);
    rnd1   = sum_nx + ACCW'(N / 2);
    dc_valid = en && (step == LOG2N'(N - 1));
  end

  // Two sources average 2N samples, one source averages N.
  always_comb begin
    dc = DC_DEF;
    if (top_avail && left_avail)
      dc = rnd2[LOG2N+1 +: PIXW];
    else if (top_avail || left_avail)
      dc = rnd1[LOG2N +: PIXW];
  end

  assign unused_bits = ^{rnd2[LOG2N:0], rnd1[LOG2N-1:0], rnd1[ACCW-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      step <= '0;
    end else if (clear) begin
      acc  <= '0;
      step <= '0;
    end else if (en) begin
      acc  <= sum_nx;
      step <= step + 1'b1;
    end
  end

endmodule

// File: rtl/intra_pred_moder_nxn.sv
// NxN intra predictor (V/H/DC), streams one predicted row per cycle
// under valid/ready once a request has been captured.
module intra_pred_moder_nxn
  import intra_pred_pkg::*;
#(
  parameter int N    = 8,
  parameter int PIXW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic                  top_avail,
  input  logic                  left_avail,
  input  logic [N*PIXW-1:0]     top_pixels,
  input  logic [N*PIXW-1:0]     left_pixels,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [N*PIXW-1:0]     row_data,
  output logic [$clog2(N)-1:0]  row_idx,
  output logic                  row_last,
  output logic                  block_done,
  output logic                  mode_err
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [PIXW-1:0] DC_DEF = PIXW'(dc_default(PIXW));

  if (!legal_n(N)) begin : g_bad_n
    $error("intra_pred_moder_nxn: N must be 4, 8 or 16");
  end

  state_t            state;
  state_t            state_nx;
  pred_mode_t        mode_q;
  logic              ta_q;
  logic              la_q;
  logic [N*PIXW-1:0] top_q;
  logic [N*PIXW-1:0] left_q;
  logic [PIXW-1:0]   dc_q;
  logic [PIXW-1:0]   dc_w;
  logic [PIXW-1:0]   h_px;
  logic              dc_valid;
  logic              capture;
  logic              accept;
  logic              last;

  assign in_ready  = (state == S_IDLE);
  assign row_valid = (state == S_EMIT);
  assign capture   = in_valid && in_ready;
  assign accept    = row_valid && row_ready;
  assign last      = (row_idx == LAST);
  assign row_last  = row_valid && last;

  intra_dc_accum #(.N(N), .PIXW(PIXW)) u_dc (
    .clk        (clk),
    .reset      (reset),
    .clear      (capture),
    .en         (state == S_ACCUM),
    .top_avail  (ta_q),
    .left_avail (la_q),
    .top_pixels (top_q),
    .left_pixels(left_q),
    .dc_valid   (dc_valid),
    .dc         (dc_w)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (capture) state_nx = mode[1] ? S_ACCUM : S_EMIT;
      S_ACCUM: if (dc_valid) state_nx = S_EMIT;
      S_EMIT:  if (accept && last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= PRED_V;
      ta_q       <= 1'b0;
      la_q       <= 1'b0;
      top_q      <= '0;
      left_q     <= '0;
      dc_q       <= '0;
      row_idx    <= '0;
      block_done <= 1'b0;
      mode_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      block_done <= accept && last;
      mode_err   <= capture && (mode == 2'd3);
      if (capture) begin
        mode_q  <= pred_mode_t'(mode);
        ta_q    <= top_avail;
        la_q    <= left_avail;
        top_q   <= top_pixels;
        left_q  <= left_pixels;
        row_idx <= '0;
      end
      if (dc_valid) dc_q <= dc_w;
      if (accept) row_idx <= row_idx + 1'b1;
    end
  end

  // Reserved mode falls through to DC.
  always_comb begin
    h_px     = la_q ? left_q[row_idx*PIXW +: PIXW] : DC_DEF;
    row_data = '0;
    if (row_valid) begin
      unique case (mode_q)
        PRED_V:  row_data = ta_q ? top_q : {N{DC_DEF}};
        PRED_H:  row_data = {N{h_px}};
        default: row_data = {N{dc_q}};
      endcase
    end
  end

endmodule

// File: tb/tb_intra_pred_moder_nxn.sv
// Self-checking bench: vector table + row scoreboard on an N=8 instance,
// hand sequences for N=16, N=4 and mid-block reset.
module tb_intra_pred_moder_nxn;

  localparam int N = 8;

  typedef struct {
    logic [1:0]  mode;
    logic        ta;
    logic        la;
    logic [63:0] top;
    logic [63:0] left;
    logic [7:0]  dc;
    int          stall_at;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  idx;
    logic        last;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, top_avail, left_avail;
  logic [1:0]  mode;
  logic [63:0] top_pixels, left_pixels, row_data;
  logic        row_valid, row_ready, row_last, block_done, mode_err;
  logic [2:0]  row_idx;

  logic         v16, rdy16, ir16, rv16, rl16, bd16, me16;
  logic [127:0] rd16;
  logic [3:0]   ri16;
  logic         v4, rdy4, ir4, rv4, rl4, bd4, me4;
  logic [31:0]  tp4, lp4, rd4;
  logic [1:0]   ri4, m4;

  intra_pred_moder_nxn #(.N(8), .PIXW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .top_avail(top_avail), .left_avail(left_avail),
    .top_pixels(top_pixels), .left_pixels(left_pixels),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .block_done(block_done),
    .mode_err(mode_err)
  );

  intra_pred_moder_nxn #(.N(16), .PIXW(8)) u16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(ir16),
    .mode(2'd2), .top_avail(1'b1), .left_avail(1'b1),
    .top_pixels({16{8'hff}}), .left_pixels({16{8'hff}}),
    .row_valid(rv16), .row_ready(rdy16), .row_data(rd16),
    .row_idx(ri16), .row_last(rl16), .block_done(bd16), .mode_err(me16)
  );

  intra_pred_moder_nxn #(.N(4), .PIXW(8)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(ir4),
    .mode(m4), .top_avail(1'b1), .left_avail(1'b1),
    .top_pixels(tp4), .left_pixels(lp4),
    .row_valid(rv4), .row_ready(rdy4), .row_data(rd4),
    .row_idx(ri4), .row_last(rl4), .block_done(bd4), .mode_err(me4)
  );

  int   checks = 0;
  int   errors = 0;
  row_t sbq[$];
  row_t e;
  vec_t vecs[8];

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endfunction

  function automatic logic [63:0] exp_row(vec_t v, int r);
    logic [7:0] p;
    case (v.mode)
      2'd0: return v.ta ? v.top : {8{8'd128}};
      2'd1: begin
        p = v.la ? v.left[r*8 +: 8] : 8'd128;
        return {8{p}};
      end
      default: return {8{v.dc}};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && row_valid && row_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got row %h expected none", row_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_row_data", row_data, e.data);
        chk("sb_row_idx", {61'd0, row_idx}, {61'd0, e.idx});
        chk("sb_row_last", {63'd0, row_last}, {63'd0, e.last});
      end
    end
  end

  task automatic drive_req(input vec_t v);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    mode = v.mode;
    top_avail = v.ta;
    left_avail = v.la;
    top_pixels = v.top;
    left_pixels = v.left;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    top_pixels = {$urandom, $urandom};
    left_pixels = {$urandom, $urandom};
    mode = 2'($urandom);
    top_avail = ~v.ta;
    left_avail = ~v.la;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, rows, g, stall, exp_lat, exp_g;
    exp_lat = v.mode[1] ? N + 1 : 1;
    exp_g = N + ((v.stall_at >= 0) ? 3 : 0);
    for (int r = 0; r < N; r++)
      sbq.push_back('{exp_row(v, r), 3'(r), r == N - 1});
    row_ready = 1'b1;
    drive_req(v);
    lat = 1;
    while (!row_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    rows = 0;
    g = 0;
    stall = 0;
    while (rows < N && g < 100) begin
      if (row_idx == v.stall_at && stall < 3) begin
        row_ready = 1'b0;
        stall++;
        chk("stall_idx", {61'd0, row_idx}, 64'(v.stall_at));
        chk("stall_data", row_data, exp_row(v, v.stall_at));
      end else begin
        row_ready = 1'b1;
      end
      if (row_valid && row_ready) rows++;
      @(posedge clk); #1; g++;
    end
    row_ready = 1'b1;
    chk("emit_cycles", 64'(g), 64'(exp_g));
    chk("block_done", {63'd0, block_done}, 64'd1);
    chk("valid_after", {63'd0, row_valid}, 64'd0);
    chk("in_ready_after", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("block_done_pulse", {63'd0, block_done}, 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({nm, "_row_valid"}, {63'd0, row_valid}, 64'd0);
    chk({nm, "_row_data"}, row_data, 64'd0);
    chk({nm, "_row_idx"}, {61'd0, row_idx}, 64'd0);
    chk({nm, "_row_last"}, {63'd0, row_last}, 64'd0);
    chk({nm, "_block_done"}, {63'd0, block_done}, 64'd0);
    chk({nm, "_mode_err"}, {63'd0, mode_err}, 64'd0);
  endtask

  task automatic quiet_after_reset(input string nm);
    int bad;
    bad = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (block_done || row_valid) bad++;
    end
    chk(nm, 64'(bad), 64'd0);
  endtask

  initial begin
    int lat, bad;
    vecs[0] = '{2'd2, 1'b1, 1'b1, {8{8'd10}}, {8{8'd20}}, 8'd15, -1};
    vecs[1] = '{2'd2, 1'b1, 1'b0, {8{8'd10}}, {8{8'hee}}, 8'd10, -1};
    vecs[2] = '{2'd2, 1'b0, 1'b1, {8{8'hff}}, 64'h0706050403020100, 8'd4, -1};
    vecs[3] = '{2'd2, 1'b0, 1'b0, {8{8'h33}}, {8{8'h44}}, 8'd128, -1};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 64'h0807060504030201, 64'd0, 8'd0, -1};
    vecs[5] = '{2'd1, 1'b1, 1'b0, {8{8'h11}}, {8{8'h22}}, 8'd0, -1};
    vecs[6] = '{2'd1, 1'b0, 1'b1, 64'd0, 64'h3938373635343332, 8'd0, 2};
    vecs[7] = '{2'd0, 1'b0, 1'b1, {8{8'h99}}, 64'd0, 8'd0, -1};

    reset = 1'b1;
    in_valid = 1'b0; mode = 2'd0; top_avail = 1'b0; left_avail = 1'b0;
    top_pixels = '0; left_pixels = '0; row_ready = 1'b1;
    v16 = 1'b0; rdy16 = 1'b1; v4 = 1'b0; rdy4 = 1'b1;
    m4 = 2'd0; tp4 = '0; lp4 = '0;
    @(posedge clk); #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // N=16 DC with all-255 neighbours must not overflow
    v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 1;
    while (!rv16 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    chk("n16_latency", 64'(lat), 64'd17);
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      if (rd16 !== {16{8'hff}} || ri16 !== 4'(r) || rl16 !== (r == 15)) bad++;
      @(posedge clk); #1;
    end
    chk("n16_rows_bad", 64'(bad), 64'd0);
    chk("n16_block_done", {63'd0, bd16}, 64'd1);
    chk("n16_mode_err", {63'd0, me16}, 64'd0);

    // N=4 reserved mode: error pulse, DC = (10+26+4)>>3 = 5
    m4 = 2'd3; tp4 = 32'h04030201; lp4 = 32'h08070605; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; m4 = 2'd0;
    chk("n4_mode_err", {63'd0, me4}, 64'd1);
    @(posedge clk); #1;
    chk("n4_mode_err_pulse", {63'd0, me4}, 64'd0);
    lat = 2;
    while (!rv4 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("n4_latency", 64'(lat), 64'd5);
    bad = 0;
    for (int r = 0; r < 4; r++) begin
      if (rd4 !== {4{8'd5}} || ri4 !== 2'(r)) bad++;
      @(posedge clk); #1;
    end
    chk("n4_rows_bad", 64'(bad), 64'd0);
    chk("n4_block_done", {63'd0, bd4}, 64'd1);

    // reset at ACCUM step 3
    drive_req(vecs[0]);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("accum_busy", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_accum");
    quiet_after_reset("rst_accum_quiet");

    // reset mid-EMIT after three rows accepted
    for (int r = 0; r < N; r++)
      sbq.push_back('{exp_row(vecs[4], r), 3'(r), r == N - 1});
    row_ready = 1'b1;
    drive_req(vecs[4]);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("emit_idx3", {61'd0, row_idx}, 64'd3);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_emit");
    chk("rst_emit_popped", 64'(sbq.size()), 64'd5);
    sbq.delete();
    quiet_after_reset("rst_emit_quiet");

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intra_pred_moder_nxn.md
Name: intra_pred_moder_nxn

Overview:
Parametrised successor to the fixed 8x8 chroma predictor. Serves NxN luma/chroma blocks (N = 4, 8, 16) and computes one selected mode per request: vertical, horizontal or DC. DC uses neighbour-availability rules and sequential accumulation. The predicted block streams out one row per cycle under a valid/ready handshake. Sits between the neighbour-pixel fetch stage and the residual/SAD stage of the intra path.

Parameters:
N, 8, block edge in pixels; legal values 4, 8, 16; anything else is an elaboration error
PIXW, 8, pixel bit width
LOG2N, derived localparam = clog2(N), not overridable

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  request valid
in_ready  output  1  block accepts a request; high only in IDLE
mode  input  2  0 = vertical, 1 = horizontal, 2 = DC, 3 = reserved
top_avail  input  1  top neighbours valid
left_avail  input  1  left neighbours valid
top_pixels  input  N*PIXW  top neighbour row; pixel i at [i*PIXW +: PIXW], i = 0 leftmost
left_pixels  input  N*PIXW  left neighbour column; pixel j at [j*PIXW +: PIXW], j = 0 topmost
row_valid  output  1  row_data valid
row_ready  input  1  downstream accepts row
row_data  output  N*PIXW  predicted row; pixel i at [i*PIXW +: PIXW]
row_idx  output  LOG2N  index of current row, 0 = top
row_last  output  1  high with row_valid when row_idx = N-1
block_done  output  1  one-cycle pulse after the last row is accepted
mode_err  output  1  one-cycle pulse when mode 3 is accepted

Behaviour:
- Reset: state IDLE. in_ready = 1. row_valid, row_last, block_done and mode_err = 0. row_data, row_idx, the captured registers and the accumulator = 0.
- Capture: on the edge where in_valid && in_ready, register mode, avail flags, top_pixels and left_pixels. Inputs are don't-care at all other times.
- FSM states: IDLE, ACCUM, EMIT.
- IDLE to EMIT on capture for modes 0 and 1.
- IDLE to ACCUM on capture for modes 2 and 3.
- Mode 3 is treated as DC. mode_err pulses in the cycle after capture.
- ACCUM lasts exactly N cycles. Cycle k (0..N-1) adds top[k] (if top_avail) and left[k] (if left_avail) into an accumulator of PIXW+LOG2N+1 bits, cleared at capture.
- On the Nth ACCUM edge, dc is registered and the FSM enters EMIT. dc is selected as follows:
  - both available: (sum + N) >> (LOG2N+1)
  - one available: (sum + N/2) >> LOG2N
  - none available: 1 << (PIXW-1)
- Latency:
  - V/H: row_valid is high in the first cycle after capture.
  - DC: row_valid is high N+1 cycles after capture.
- Row content:
  - vertical: pixel i = top[i], or 1<<(PIXW-1) if !top_avail
  - horizontal: every pixel = left[row_idx], or 1<<(PIXW-1) if !left_avail
  - DC: every pixel = dc
- EMIT: row_valid stays high. row_idx advances only on row_valid && row_ready. row_data and row_idx hold stable while row_ready is low.
- Last row: on acceptance of row N-1, the FSM enters IDLE. In the next cycle row_valid = 0, in_ready = 1 and block_done = 1. A new request may be captured in that same cycle.
- Reset asserted mid-ACCUM or mid-EMIT: immediate return to reset values. No block_done. The partial block is discarded.
- No combinational path from in_valid to in_ready or from row_ready to row_valid.

Decomposition:
- Shared package intra_pred_pkg holds:
  - mode enum (PRED_V, PRED_H, PRED_DC, PRED_RSVD)
  - FSM state enum
  - function dc_default(PIXW)
  - legal-N check
- One sub-module, intra_dc_accum: accumulator, step counter and rounding/shift. It raises dc_valid with dc on the final step.

Test Plan:
- N=8, DC, both available, top all 10, left all 20 -> dc = (80+160+8)>>4 = 15. 8 rows of all-15. First row_valid 9 cycles after capture. block_done one cycle after row 7 is accepted.
- N=8, DC, top only, top all 10 -> 10. Left only, left = 0..7 -> (28+4)>>3 = 4. Neither available -> 128.
- N=8, vertical, top = 1..8, row_ready held high -> rows 0..7 each {1..8} on consecutive cycles, starting 1 cycle after capture. Horizontal with !left_avail -> all 128.
- N=8, horizontal, left = 50..57, row_ready low for 3 cycles at row_idx 2 -> row_data = all-52 and row_idx = 2 held stable. Advances to row 3 when row_ready returns.
- N=16, DC, all neighbours 255 -> (8160+16)>>5 = 255, no overflow. N=4, mode 3 -> mode_err pulse and DC output.
- Reset asserted at ACCUM step 3 and again mid-EMIT -> all outputs 0, in_ready = 1, no block_done. The next request completes normally.
